// File: rtl/ddr_package.sv
// Shared types and default timing for the DDR read/write scheduler.
package ddr_package;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4
    } ddr_cmd_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ACT   = 3'd1,
        S_TRCD  = 3'd2,
        S_CAS   = 3'd3,
        S_BURST = 3'd4,
        S_PRE   = 3'd5,
        S_TRP   = 3'd6
    } sched_fsm_type;

    localparam int DEF_T_RCD   = 14;
    localparam int DEF_T_BURST = 4;
    localparam int DEF_T_RP    = 14;
    localparam int CNT_W       = 8;

endpackage

// File: rtl/ddr_req_fifo.sv
// Synchronous request FIFO with registered occupancy count.
module ddr_req_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clock_t,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == LVL_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem[rd_ptr_q];

    // NOTE: every signal written here gets a default first, so no path can leave a latch.
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + LVL_W'(1);
            2'b01:   count_d = count_q - LVL_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock_t) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; the pointers and count alone decide which entries are live.
    always_ff @(posedge clock_t) begin
        if (do_push) mem[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/ddr_rw_scheduler.sv
// Closed-page read/write scheduler: queues host requests and issues ACT -> RD/WR -> PRE per request.
module ddr_rw_scheduler
    import ddr_package::*;
#(
    parameter int DEPTH   = 8,
    parameter int BANK_W  = 4,
    parameter int ROW_W   = 17,
    parameter int COL_W   = 10,
    parameter int T_RCD   = DEF_T_RCD,
    parameter int T_BURST = DEF_T_BURST,
    parameter int T_RP    = DEF_T_RP
) (
    input  logic                            clock_t,
    input  logic                            reset,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic                            req_write,
    input  logic [BANK_W+ROW_W+COL_W-1:0]   req_addr,
    input  logic                            rw_proc,
    output logic                            rw_idle,
    output logic                            cmd_valid,
    output logic [2:0]                      cmd_type,
    output logic [BANK_W-1:0]               cmd_bank,
    output logic [ROW_W-1:0]                cmd_row,
    output logic [COL_W-1:0]                cmd_col,
    output logic                            done_valid,
    output logic                            done_write,
    output logic [$clog2(DEPTH):0]          q_level
);

    localparam int ADDR_W = BANK_W + ROW_W + COL_W;
    localparam logic [CNT_W-1:0] RCD_LD   = CNT_W'(T_RCD - 1);
    localparam logic [CNT_W-1:0] BURST_LD = CNT_W'(T_BURST - 1);
    localparam logic [CNT_W-1:0] RP_LD    = CNT_W'(T_RP - 1);

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [ADDR_W:0]   head_data;
    logic              head_write;
    logic [BANK_W-1:0] head_bank;
    logic [ROW_W-1:0]  head_row;
    logic [COL_W-1:0]  head_col;

    sched_fsm_type     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cmd_valid_q, cmd_valid_d;
    ddr_cmd_t          cmd_type_q, cmd_type_d;
    logic [BANK_W-1:0] cmd_bank_q, cmd_bank_d;
    logic [ROW_W-1:0]  cmd_row_q, cmd_row_d;
    logic [COL_W-1:0]  cmd_col_q, cmd_col_d;
    logic              done_valid_q, done_valid_d;
    logic              done_write_q, done_write_d;
    logic              rw_idle_q, rw_idle_d;
    logic              txn_write_q, txn_write_d;
    logic [BANK_W-1:0] txn_bank_q, txn_bank_d;
    logic [COL_W-1:0]  txn_col_q, txn_col_d;

    assign req_ready = !fifo_full;
    assign fifo_push = req_valid && req_ready;

    ddr_req_fifo #(
        .WIDTH (ADDR_W + 1),
        .DEPTH (DEPTH)
    ) u_req_fifo (
        .clock_t (clock_t),
        .reset   (reset),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data ({req_write, req_addr}),
        .rd_data (head_data),
        .count   (q_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign head_write = head_data[ADDR_W];
    assign head_bank  = head_data[ADDR_W-1 -: BANK_W];
    assign head_row   = head_data[COL_W +: ROW_W];
    assign head_col   = head_data[COL_W-1:0];

    // Commands are registered on the edge that enters the issuing state, and that state
    // counts as the first cycle of the following wait, so spacing equals the parameter.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cmd_valid_d  = 1'b0;
        cmd_type_d   = CMD_NOP;
        cmd_bank_d   = cmd_bank_q;
        cmd_row_d    = cmd_row_q;
        cmd_col_d    = cmd_col_q;
        done_valid_d = 1'b0;
        done_write_d = done_write_q;
        txn_write_d  = txn_write_q;
        txn_bank_d   = txn_bank_q;
        txn_col_d    = txn_col_q;
        fifo_pop     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rw_proc && !fifo_empty) begin
                    fifo_pop    = 1'b1;
                    txn_write_d = head_write;
                    txn_bank_d  = head_bank;
                    txn_col_d   = head_col;
                    cmd_valid_d = 1'b1;
                    cmd_type_d  = CMD_ACT;
                    cmd_bank_d  = head_bank;
                    cmd_row_d   = head_row;
                    cnt_d       = RCD_LD;
                    state_d     = S_ACT;
                end
            end
            S_ACT, S_TRCD: begin
                if (cnt_q == '0) begin
                    cmd_valid_d = 1'b1;
                    cmd_type_d  = txn_write_q ? CMD_WR : CMD_RD;
                    cmd_bank_d  = txn_bank_q;
                    cmd_col_d   = txn_col_q;
                    cnt_d       = BURST_LD;
                    state_d     = S_CAS;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    state_d = S_TRCD;
                end
            end
            S_CAS, S_BURST: begin
                if (cnt_q == '0) begin
                    cmd_valid_d  = 1'b1;
                    cmd_type_d   = CMD_PRE;
                    cmd_bank_d   = txn_bank_q;
                    done_valid_d = 1'b1;
                    done_write_d = txn_write_q;
                    cnt_d        = RP_LD;
                    state_d      = S_PRE;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    state_d = S_BURST;
                end
            end
            S_PRE, S_TRP: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    state_d = S_TRP;
                end
            end
            default: state_d = S_IDLE;
        endcase

        rw_idle_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clock_t) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            cmd_valid_q  <= 1'b0;
            cmd_type_q   <= CMD_NOP;
            cmd_bank_q   <= '0;
            cmd_row_q    <= '0;
            cmd_col_q    <= '0;
            done_valid_q <= 1'b0;
            done_write_q <= 1'b0;
            rw_idle_q    <= 1'b1;
            txn_write_q  <= 1'b0;
            txn_bank_q   <= '0;
            txn_col_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_type_q   <= cmd_type_d;
            cmd_bank_q   <= cmd_bank_d;
            cmd_row_q    <= cmd_row_d;
            cmd_col_q    <= cmd_col_d;
            done_valid_q <= done_valid_d;
            done_write_q <= done_write_d;
            rw_idle_q    <= rw_idle_d;
            txn_write_q  <= txn_write_d;
            txn_bank_q   <= txn_bank_d;
            txn_col_q    <= txn_col_d;
        end
    end

    assign rw_idle    = rw_idle_q;
    assign cmd_valid  = cmd_valid_q;
    assign cmd_type   = cmd_type_q;
    assign cmd_bank   = cmd_bank_q;
    assign cmd_row    = cmd_row_q;
    assign cmd_col    = cmd_col_q;
    assign done_valid = done_valid_q;
    assign done_write = done_write_q;

endmodule
